// File: rtl/riscv_mem_dma_pkg.sv
// Shared types and default memory-map constants for the riscv_mem_dma word-copy engine.
package riscv_mem_dma_pkg;

    localparam logic [31:0] DATA_BASE_DEFAULT = 32'h00800000;
    localparam logic [31:0] TEXT_BASE_DEFAULT = 32'h00400000;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        DONE,
        ERR
    } dma_state_e;

endpackage

// File: rtl/riscv_mem_dma_range_check.sv
// Checks that [base, base + 4*count) lies inside one 2^SEG_LOG2-byte segment.
module riscv_mem_dma_range_check
    import riscv_mem_dma_pkg::*;
#(
    parameter logic [31:0] SEG_BASE = DATA_BASE_DEFAULT,
    parameter int unsigned SEG_LOG2 = 13
) (
    input  logic [31:0] base_i,
    input  logic [15:0] count_i,
    output logic        in_range_o
);

    logic [32:0] seg_lo;
    logic [32:0] seg_hi;
    logic [32:0] end_addr;

    // 33-bit end address so a range wrapping past 2^32 is rejected
    assign seg_lo     = {1'b0, SEG_BASE};
    assign seg_hi     = seg_lo + (33'd1 << SEG_LOG2);
    assign end_addr   = {1'b0, base_i} + {15'd0, count_i, 2'b00};
    assign in_range_o = ({1'b0, base_i} >= seg_lo) && (end_addr <= seg_hi);

endmodule

// File: rtl/riscv_mem_dma.sv
// Word-copy DMA on the processor data port (2 cycles per word, forward order).
// Optional running checksum of copied words: define RISCV_MEM_DMA_CHECKSUM_EN.
module riscv_mem_dma
    import riscv_mem_dma_pkg::*;
#(
    parameter logic [31:0] DATA_START_ADDRESS = DATA_BASE_DEFAULT,
    parameter int unsigned DATA_BRAMS         = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] src_addr,
    input  logic [31:0] dst_addr,
    input  logic [15:0] word_count,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] dAddress,
    output logic        MemWrite,
    output logic [31:0] dWriteData,
    input  logic [31:0] dReadData,
    output logic [31:0] checksum
);

    dma_state_e  state_q;
    logic [31:0] src_q;
    logic [31:0] dst_q;
    logic [15:0] remaining_q;
    logic        src_ok;
    logic        dst_ok;
    logic        misaligned;

    riscv_mem_dma_range_check #(
        .SEG_BASE (DATA_START_ADDRESS),
        .SEG_LOG2 (11 + DATA_BRAMS)
    ) u_src_check (
        .base_i     (src_addr),
        .count_i    (word_count),
        .in_range_o (src_ok)
    );

    riscv_mem_dma_range_check #(
        .SEG_BASE (DATA_START_ADDRESS),
        .SEG_LOG2 (11 + DATA_BRAMS)
    ) u_dst_check (
        .base_i     (dst_addr),
        .count_i    (word_count),
        .in_range_o (dst_ok)
    );

    assign misaligned = (src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            remaining_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        src_q       <= src_addr;
                        dst_q       <= dst_addr;
                        remaining_q <= word_count;
                        // alignment is checked first; a zero-length copy skips the range test
                        if (misaligned)                 state_q <= ERR;
                        else if (word_count == 16'd0)   state_q <= DONE;
                        else if (!(src_ok && dst_ok))   state_q <= ERR;
                        else                            state_q <= READ;
                    end
                end
                READ:  state_q <= WRITE;
                WRITE: begin
                    src_q       <= src_q + 32'd4;
                    dst_q       <= dst_q + 32'd4;
                    remaining_q <= remaining_q - 16'd1;
                    state_q     <= (remaining_q == 16'd1) ? DONE : READ;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy       = (state_q == READ) || (state_q == WRITE);
    assign done       = (state_q == DONE);
    assign error      = (state_q == ERR);
    assign MemWrite   = (state_q == WRITE);
    assign dWriteData = MemWrite ? dReadData : '0;

    always_comb begin
        dAddress = '0;
        case (state_q)
            READ:    dAddress = src_q;
            WRITE:   dAddress = dst_q;
            default: dAddress = '0;
        endcase
    end

`ifdef RISCV_MEM_DMA_CHECKSUM_EN
    logic [31:0] checksum_q;

    always_ff @(posedge clk) begin
        if (rst)                           checksum_q <= '0;
        else if (state_q == IDLE && start) checksum_q <= '0;
        else if (state_q == WRITE)         checksum_q <= checksum_q + dReadData;
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_riscv_mem_dma.sv
// Bench for riscv_mem_dma: data memory model, per-cycle trace scoreboard and directed copies.
module tb_riscv_mem_dma;

    localparam logic [31:0] BASE   = 32'h00800000;
    localparam int unsigned WORDS  = 2048;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic [15:0] word_count = '0;
    logic        busy, done, error, MemWrite;
    logic [31:0] dAddress, dWriteData, dReadData, checksum;

    always #5 clk = ~clk;

    riscv_mem_dma #(
        .DATA_START_ADDRESS (32'h00800000),
        .DATA_BRAMS         (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .dAddress   (dAddress),
        .MemWrite   (MemWrite),
        .dWriteData (dWriteData),
        .dReadData  (dReadData),
        .checksum   (checksum)
    );

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] init_word(input int unsigned i);
        return (i < 4) ? 32'(i + 1) : (32'hA5000000 | 32'(i));
    endfunction

    function automatic int unsigned widx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    // Data memory: one-cycle synchronous read, write on MemWrite.
    logic [31:0] mem [0:WORDS-1];
    logic        init_mem = 1'b1;
    int          n_writes = 0;

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= init_word(i);
            dReadData <= '0;
        end else if (dAddress >= BASE && dAddress < BASE + 32'd8192) begin
            dReadData <= mem[widx(dAddress)];
            if (MemWrite) begin
                mem[widx(dAddress)] <= dWriteData;
                n_writes <= n_writes + 1;
            end
        end else begin
            dReadData <= '0;
        end
    end

    // Expected per-cycle behaviour, generated from the copy rules.
    typedef struct {
        bit          busy;
        bit          done;
        bit          err;
        bit          wr;
        bit          clr;
        logic [31:0] addr;
        logic [31:0] rd_addr;
    } exp_t;

    exp_t        q[$];
    logic [31:0] model_mem [0:WORDS-1];
    logic [31:0] cks = '0;
    bit          chk_en = 1'b0;
    bit          busy_seen = 1'b0;

    function automatic void push_trace(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
        logic [63:0] lo, hi, s64, d64, len;
        bit          bad;
        exp_t        e;
        lo  = 64'h00800000;
        hi  = lo + 64'd8192;
        s64 = {32'd0, s};
        d64 = {32'd0, d};
        len = 64'd4 * {48'd0, n};
        e = '{default: 0};
        q.push_back(e);
        bad = (s % 4 != 0) || (d % 4 != 0) ||
              (n != 0 && (s64 < lo || s64 + len > hi || d64 < lo || d64 + len > hi));
        if (bad) begin
            e.err = 1; e.clr = 1; q.push_back(e); return;
        end
        for (int unsigned i = 0; i < n; i++) begin
            e = '{default: 0};
            e.busy = 1; e.addr = s + 32'(4 * i); e.clr = (i == 0);
            q.push_back(e);
            e = '{default: 0};
            e.busy = 1; e.wr = 1; e.addr = d + 32'(4 * i); e.rd_addr = s + 32'(4 * i);
            q.push_back(e);
        end
        e = '{default: 0};
        e.done = 1; e.clr = (n == 0);
        q.push_back(e);
    endfunction

    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] wd, exp_cks;
        if (chk_en) begin
            if (q.size() != 0) e = q.pop_front();
            else e = '{default: 0};
            if (e.clr) cks = '0;
            wd = e.wr ? model_mem[widx(e.rd_addr)] : 32'd0;
`ifdef RISCV_MEM_DMA_CHECKSUM_EN
            exp_cks = cks;
`else
            exp_cks = 32'd0;
`endif
            chk("cycle", {busy, done, error, MemWrite, dAddress, dWriteData, checksum},
                         {e.busy, e.done, e.err, e.wr, e.addr, wd, exp_cks});
            if (busy) busy_seen = 1'b1;
            if (e.wr) begin
                model_mem[widx(e.addr)] = wd;
                cks = cks + wd;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the sampling edge.
    task automatic drive_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
        src_addr = s; dst_addr = d; word_count = n; start = 1'b1;
        push_trace(s, d, n);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts cycles until done (or error) is seen; a timeout shows up as a wrong count.
    task automatic wait_end(input string name, input bit want_err, input int exp_lat);
        int cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if ((want_err ? error : done) === 1'b1 || cyc >= 64) break;
        end
        chk(name, 128'(cyc), 128'(exp_lat));
        @(posedge clk); #1;
    endtask

    int w0;

    initial begin
        for (int i = 0; i < WORDS; i++) model_mem[i] = init_word(i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {busy, done, error, MemWrite, dAddress, dWriteData, checksum}, '0);
        @(posedge clk); #1;
        rst = 1'b0; init_mem = 1'b0; chk_en = 1'b1;
        @(posedge clk); #1;

        // Four-word copy.
        w0 = n_writes;
        drive_start(32'h00800000, 32'h00800100, 16'd4);
        wait_end("copy4_latency", 1'b0, 9);
        chk("copy4_writes", 128'(n_writes - w0), 128'd4);
        for (int i = 0; i < 4; i++) chk("copy4_data", mem[32'h40 + i], 32'(i + 1));
`ifdef RISCV_MEM_DMA_CHECKSUM_EN
        chk("copy4_checksum", checksum, 32'd10);
`else
        chk("copy4_checksum", checksum, 32'd0);
`endif

        // Zero-length copy.
        w0 = n_writes; busy_seen = 1'b0;
        drive_start(32'h00800010, 32'h00800020, 16'd0);
        wait_end("zero_latency", 1'b0, 1);
        chk("zero_writes", 128'(n_writes - w0), 128'd0);
        chk("zero_busy", 128'(busy_seen), 128'd0);

        // Rejected requests: misaligned, range end past segment, 32-bit wrap.
        w0 = n_writes;
        drive_start(32'h00800002, 32'h00800100, 16'd1);
        wait_end("err_misaligned", 1'b1, 1);
        drive_start(32'h00800000, 32'h00801FFC, 16'd2);
        wait_end("err_past_end", 1'b1, 1);
        drive_start(32'hFFFFFFFC, 32'h00800000, 16'd2);
        wait_end("err_wrap", 1'b1, 1);
        chk("err_writes", 128'(n_writes - w0), 128'd0);

        // Last word of the segment is a legal destination.
        drive_start(32'h00800010, 32'h00801FFC, 16'd1);
        wait_end("edge_latency", 1'b0, 3);
        chk("edge_data", mem[WORDS-1], 32'hA5000004);

        // Reset during an 8-word copy, sampled in the third cycle.
        w0 = n_writes;
        drive_start(32'h00800200, 32'h00800300, 16'd8);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; q.delete(); cks = '0;
        @(negedge clk);
        chk("rst_memwrite", {busy, MemWrite}, 2'b00);
        @(posedge clk); #1;
        chk("rst_writes", 128'(n_writes - w0), 128'd1);
        chk("rst_word0", mem[32'hC0], 32'hA5000080);
        chk("rst_word1", mem[32'hC1], 32'hA50000C1);

        // Second start while busy is ignored.
        drive_start(32'h00800400, 32'h00800500, 16'd3);
        @(posedge clk); #1;
        src_addr = 32'h00800000; dst_addr = 32'h00800600; word_count = 16'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_end("busy_latency", 1'b0, 5);
        chk("busy_ignored", mem[32'h180], 32'hA5000180);
        chk("busy_data", mem[32'h142], 32'hA5000102);

        // Overlapping forward copy replicates word 0.
        drive_start(32'h00800000, 32'h00800004, 16'd3);
        wait_end("overlap_latency", 1'b0, 7);
        for (int i = 1; i < 4; i++) chk("overlap_data", mem[i], 32'd1);
`ifdef RISCV_MEM_DMA_CHECKSUM_EN
        chk("overlap_checksum", checksum, 32'd3);
`else
        chk("overlap_checksum", checksum, 32'd0);
`endif

        repeat (3) @(posedge clk);
        #1;
        begin
            int bad = 0;
            for (int i = 0; i < WORDS; i++) if (mem[i] !== model_mem[i]) bad++;
            chk("memory_image", 128'(bad), 128'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/riscv_mem_dma.md
RISCV_MEM_DMA -- requirements
Module: riscv_mem_dma

Interface
REQ-001 SHALL have parameter DATA_START_ADDRESS, default 32'h00800000, base byte address of the data segment.
REQ-002 SHALL have parameter DATA_BRAMS, default 2, data memory size in BRAMs; segment size = 2^(11+DATA_BRAMS) bytes.
REQ-003 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports start in 1 (copy request pulse), src_addr in 32, dst_addr in 32 (byte addresses), word_count in 16 (words to copy).
REQ-006 SHALL have ports busy out 1 (copy in progress), done out 1 (one-cycle completion pulse), error out 1 (one-cycle rejection pulse).
REQ-007 SHALL have data-port initiator outputs dAddress out 32, MemWrite out 1, dWriteData out 32, and input dReadData in 32, matching the processor data memory port with one-cycle synchronous read latency.
REQ-008 SHALL have port checksum out 32, wrapping sum of copied words (see Configuration).

Function
REQ-009 SHALL implement FSM states IDLE, READ, WRITE, DONE, ERR; all outputs decoded from state and registered pointers only.
REQ-010 In IDLE, start=1 SHALL latch src/dst/count and move to READ, DONE or ERR on the next edge.
REQ-011 Start SHALL go to ERR if src_addr[1:0]!=0, dst_addr[1:0]!=0, or either range [addr, addr+4*word_count) leaves the data segment; no memory access SHALL occur.
REQ-012 Start with word_count=0 and valid alignment SHALL go directly to DONE, no memory access.
REQ-013 READ: dAddress=current src pointer, MemWrite=0; next state WRITE.
REQ-014 WRITE: dAddress=current dst pointer, MemWrite=1, dWriteData=dReadData; pointers += 4, remaining -= 1; next state READ, or DONE when remaining reaches 0.
REQ-015 Each word SHALL take exactly 2 cycles; done asserted exactly 2N+1 cycles after the edge sampling start.
REQ-016 Copy SHALL proceed in ascending address order; overlapping ranges SHALL yield word-by-word forward-copy semantics.
REQ-017 DONE and ERR SHALL each last one cycle asserting done or error respectively, then return to IDLE.
REQ-018 busy SHALL be 1 in READ and WRITE only; start while not IDLE SHALL be ignored.
REQ-019 In IDLE, DONE, ERR: dAddress=0, MemWrite=0, dWriteData=0.
REQ-020 Address arithmetic SHALL be 32-bit unsigned; range check SHALL use 33-bit end address so wrap past 2^32 is an error.

Reset
REQ-021 rst SHALL force IDLE on the next edge, aborting any copy; MemWrite=0 from the following cycle.
REQ-022 Reset values: busy=0, done=0, error=0, dAddress=0, MemWrite=0, dWriteData=0, checksum=0; latched pointers and count cleared.

Configuration
REQ-023 Macro RISCV_MEM_DMA_CHECKSUM_EN defined: checksum cleared on accepted start, adds dReadData (mod 2^32) in each WRITE cycle, holds after done until next start.
REQ-024 Macro undefined: checksum port present and tied to 32'h0, no accumulator logic.

Structure
REQ-025 Package riscv_mem_dma_pkg SHALL hold the FSM state enum typedef and default segment constants (32'h00800000 data base, 32'h00400000 text base).
REQ-026 Sub-module riscv_mem_dma_range_check (combinational: base, count, segment params -> in_range) SHALL be instantiated twice, for src and dst.

Verification
REQ-027 Bench SHALL pair the block with the processor data memory model and cover:
REQ-028 src=0x00800000, dst=0x00800100, count=4, words 1,2,3,4 -> dst holds 1..4, done pulse 9 cycles after start, checksum=10 with macro.
REQ-029 count=0 -> done next cycle+1, MemWrite never asserted, busy stays 0.
REQ-030 src=0x00800002 or dst=0x00801FFC count=2 (DATA_BRAMS=2) -> error pulse, no writes, done never asserted.
REQ-031 rst asserted after 3 cycles of count=8 copy -> IDLE, MemWrite=0 next cycle, only first word written.
REQ-032 start re-pulsed while busy -> ignored; overlap src=0x00800000, dst=0x00800004, count=3 -> forward-copy result (word0 replicated).
